// File: rtl/audio_pwm_mixer_nchan_pkg.sv
// Shared definitions for the N-channel PWM audio mixer.
// Also provides the codebase-wide audio macros: the default pulse-width
// resolution (`BITRES) and the mixing-mode selectors (`AUDIO_MIX_MUX,
// `AUDIO_MIX_SUM). Compile this file before the mixer sources.

`ifndef BITRES
`define BITRES 8
`endif
`ifndef AUDIO_MIX_MUX
`define AUDIO_MIX_MUX 0
`endif
`ifndef AUDIO_MIX_SUM
`define AUDIO_MIX_SUM 1
`endif

package audio_pwm_mixer_nchan_pkg;

  // Mixing modes: one PWM slot per channel, or one summed pulse per frame.
  localparam int MIX_MUX = `AUDIO_MIX_MUX;
  localparam int MIX_SUM = `AUDIO_MIX_SUM;

  // Frame length in clocks for a given channel count and resolution.
  function automatic int frame_len(input int nchan, input int bitres);
    return 1 << (bitres + $clog2(nchan));
  endfunction

endpackage

// File: rtl/audio_frame_counter.sv
// Free-running frame counter for the PWM mixer.
//   clk, resetn : clock, async active-low reset
//   mute        : synchronous clear, active high
//   fc          : frame position, wraps from 2^FW-1 to 0
//   load        : high while fc is at its last count (shadow load edge);
//                 suppressed by mute so a muted boundary never loads
//   frame_start : registered, high for the single cycle where fc == 0
//                 following a load edge

module audio_frame_counter #(
  parameter int FW = 10
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          mute,
  output logic [FW-1:0] fc,
  output logic          load,
  output logic          frame_start
);

  assign load = (fc == {FW{1'b1}}) && !mute;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fc          <= '0;
      frame_start <= 1'b0;
    end else if (mute) begin
      fc          <= '0;
      frame_start <= 1'b0;
    end else begin
      fc          <= fc + {{(FW-1){1'b0}}, 1'b1};
      frame_start <= load;
    end
  end

endmodule

// File: rtl/audio_pwm_mixer_nchan.sv
// N-channel PWM audio mixer driving a single 1-bit output pin.
//   clk, resetn : clock, async active-low reset
//   mute        : synchronous clear of counter, shadows and output
//   chan_en     : per-channel enable, sampled at the frame boundary
//   pulsewidth  : packed widths, channel i at [i*BITRES +: BITRES]
//   audout      : registered PWM output (lags the counter by one clock)
//   frame_start : one-clock strobe, new shadow values in use this cycle
// MODE selects time-multiplexed slots or one summed pulse; only the
// selected datapath is elaborated. Widths are double-buffered so
// upstream may change them at any time without glitching a frame.

module audio_pwm_mixer_nchan
  import audio_pwm_mixer_nchan_pkg::*;
#(
  parameter int NCHAN  = 4,
  parameter int BITRES = `BITRES,
  parameter int MODE   = `AUDIO_MIX_MUX
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    mute,
  input  logic [NCHAN-1:0]        chan_en,
  input  logic [NCHAN*BITRES-1:0] pulsewidth,
  output logic                    audout,
  output logic                    frame_start
);

  localparam int CW = $clog2(NCHAN);
  localparam int FW = BITRES + CW;

  logic [FW-1:0]                  fc;
  logic                           load;
  logic                           audout_nxt;
  logic [NCHAN-1:0][BITRES-1:0]   eff;

  // Disabled channels contribute a zero width.
  for (genvar i = 0; i < NCHAN; i++) begin : g_eff
    assign eff[i] = chan_en[i] ? pulsewidth[i*BITRES +: BITRES] : '0;
  end

  audio_frame_counter #(.FW(FW)) u_fc (
    .clk         (clk),
    .resetn      (resetn),
    .mute        (mute),
    .fc          (fc),
    .load        (load),
    .frame_start (frame_start)
  );

  if (MODE == MIX_MUX) begin : g_mux
    logic [NCHAN-1:0][BITRES-1:0] shadow;
    logic [CW-1:0]                slot;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)   shadow <= '0;
      else if (mute) shadow <= '0;
      else if (load) shadow <= eff;
    end

    // Upper counter bits pick the channel, lower bits are the slot phase.
    assign slot       = fc[FW-1:BITRES];
    assign audout_nxt = fc[BITRES-1:0] < shadow[slot];
  end else begin : g_sum
    logic [FW-1:0] sum;
    logic [FW-1:0] sum_nxt;

    // FW bits hold NCHAN*(2^BITRES-1) without overflow.
    always_comb begin
      sum_nxt = '0;
      for (int i = 0; i < NCHAN; i++)
        sum_nxt = sum_nxt + {{CW{1'b0}}, eff[i]};
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)   sum <= '0;
      else if (mute) sum <= '0;
      else if (load) sum <= sum_nxt;
    end

    assign audout_nxt = fc < sum;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   audout <= 1'b0;
    else if (mute) audout <= 1'b0;
    else           audout <= audout_nxt;
  end

endmodule

// File: tb/tb_audio_pwm_mixer_nchan.sv
// Directed bench for audio_pwm_mixer_nchan: one instance per mode driven
// from the same inputs. Effective widths are queued when inputs are
// driven for a frame and popped when that frame's output has been
// sampled; each frame is compared sample-by-sample against the ideal
// waveform built from the queued widths.

module tb_audio_pwm_mixer_nchan;

  localparam int NCH   = 4;
  localparam int BR    = 8;
  localparam int SLOT  = 256;
  localparam int FRAME = 1024;
  localparam logic [31:0] PWA = 32'h80FF0040; // ch0=40 ch1=00 ch2=FF ch3=80
  localparam logic [31:0] PWB = 32'h7F0001FF; // ch0=FF ch1=01 ch2=00 ch3=7F

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mute = 1'b0;
  logic [3:0]  chan_en = '0;
  logic [31:0] pulsewidth = '0;
  logic        a0, fs0, a1, fs1;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  audio_pwm_mixer_nchan #(.NCHAN(NCH), .BITRES(BR), .MODE(0)) dut_mux (
    .clk(clk), .resetn(resetn), .mute(mute), .chan_en(chan_en),
    .pulsewidth(pulsewidth), .audout(a0), .frame_start(fs0));

  audio_pwm_mixer_nchan #(.NCHAN(NCH), .BITRES(BR), .MODE(1)) dut_sum (
    .clk(clk), .resetn(resetn), .mute(mute), .chan_en(chan_en),
    .pulsewidth(pulsewidth), .audout(a1), .frame_start(fs1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] eff_of(input logic [31:0] pw, input logic [3:0] en);
    logic [31:0] r;
    for (int i = 0; i < NCH; i++) r[i*8 +: 8] = en[i] ? pw[i*8 +: 8] : 8'h00;
    return r;
  endfunction

  task automatic drive_push(input logic [31:0] pw, input logic [3:0] en);
    pulsewidth = pw;
    chan_en    = en;
    exp_q.push_back(eff_of(pw, en));
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {28'd0, a0, a1, fs0, fs1}, 32'd0);
  endtask

  // Starts at a negedge where fc == 0; expects an all-low frame with the
  // next frame_start on the 1024th clock.
  task automatic silent_frame(input string tag, input logic [31:0] pw, input logic [3:0] en);
    int h = 0, fsbad = 0, fsend = 0;
    drive_push(pw, en);
    for (int j = 1; j <= FRAME; j++) begin
      @(negedge clk);
      h += int'(a0) + int'(a1);
      if (j < FRAME) fsbad += int'(fs0) + int'(fs1);
      else           fsend  = int'(fs0) + int'(fs1);
    end
    chk({tag, "_highs"}, h, 0);
    chk({tag, "_fs_early"}, fsbad, 0);
    chk({tag, "_fs_end"}, fsend, 2);
  endtask

  // Starts at a frame_start negedge; checks the frame against the head of
  // the queue. Next-frame inputs are driven at sample chg_at (or at once
  // when chg_at < 0), which must not disturb the frame being measured.
  task automatic measure_frame(input string tag, input logic [31:0] pw,
                               input logic [3:0] en, input int chg_at);
    logic [31:0] w;
    int tot = 0, h0 = 0, h1 = 0, mm0 = 0, mm1 = 0, fsbad = 0, fsend = 0, qn;
    logic e0, e1;
    qn = exp_q.size();
    chk({tag, "_queued"}, (qn > 0) ? 1 : 0, 1);
    w = (qn > 0) ? exp_q[0] : 32'd0;
    for (int i = 0; i < NCH; i++) tot += int'(w[i*8 +: 8]);
    if (chg_at < 0) drive_push(pw, en);
    for (int j = 1; j <= FRAME; j++) begin
      int i;
      @(negedge clk);
      i  = j - 1;
      e0 = (i % SLOT) < int'(w[(i / SLOT) * 8 +: 8]);
      e1 = i < tot;
      h0 += int'(a0);
      h1 += int'(a1);
      if (a0 !== e0) mm0++;
      if (a1 !== e1) mm1++;
      if (j < FRAME) fsbad += int'(fs0) + int'(fs1);
      else           fsend  = int'(fs0) + int'(fs1);
      if (j == chg_at) drive_push(pw, en);
    end
    if (qn > 0) void'(exp_q.pop_front());
    chk({tag, "_mux_highs"}, h0, tot);
    chk({tag, "_mux_wave"}, mm0, 0);
    chk({tag, "_sum_highs"}, h1, tot);
    chk({tag, "_sum_wave"}, mm1, 0);
    chk({tag, "_fs_early"}, fsbad, 0);
    chk({tag, "_fs_end"}, fsend, 2);
  endtask

  initial begin
    // Reset held with live inputs: outputs stay low.
    pulsewidth = PWA;
    chan_en    = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_quiet("rst_hold");
    end
    resetn = 1'b1;
    silent_frame("rst_first", PWA, 4'hF);

    measure_frame("f1_pwa",     PWA,           4'hF,    -1);  // 447
    measure_frame("f2_pwa",     PWA,           4'b0101, -1);  // 447, next 319
    measure_frame("f3_en0101",  PWA,           4'hF,    600); // 319 despite toggle
    measure_frame("f4_pwa",     PWB,           4'hF,    300); // 447 despite pw change
    measure_frame("f5_pwb",     PWA,           4'h0,    -1);  // 383 edge widths
    measure_frame("f6_alloff",  32'hFFFFFFFF,  4'hF,    -1);  // 0
    measure_frame("f7_allmax",  PWA,           4'hF,    -1);  // 1020

    // Mute mid-frame for three clocks.
    run_cycles(500);
    mute = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_quiet("mute500");
    end
    mute = 1'b0;
    exp_q.delete();
    silent_frame("mute500_after", PWA, 4'hF);
    measure_frame("mute500_resume", PWA, 4'hF, -1);

    // Mute on the load edge: no load, no frame_start.
    run_cycles(1023);
    mute = 1'b1;
    @(negedge clk);
    chk_quiet("mute1023");
    mute = 1'b0;
    exp_q.delete();
    silent_frame("mute1023_after", PWA, 4'hF);
    measure_frame("mute1023_resume", PWA, 4'hF, -1);

    // Asynchronous reset while both outputs are high.
    run_cycles(10);
    chk("areset_pre", {30'd0, a0, a1}, 32'd3);
    #2 resetn = 1'b0;
    #1 chk("areset_now", {30'd0, a0, a1}, 32'd0);
    run_cycles(2);
    resetn = 1'b1;
    exp_q.delete();
    silent_frame("areset_after", PWB, 4'hF);
    measure_frame("areset_resume", PWA, 4'hF, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
